// File: rtl/ifu_pc_pkg.sv
// Shared types and constants for the IFU F-stage per-thread PC generator.
package ifu_pc_pkg;

    localparam int NUM_THR = 4;
    localparam int PC_W    = 48;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [NUM_THR-1:0] thr_oh_t;

    localparam pc_t PC_INC_DEF   = 48'd4;
    localparam pc_t RESET_PC_DEF = 48'h0000_0FFF_F000_0020;

    // Index of the set bit of a one-hot thread vector; 0 when no bit is set.
    function automatic logic [1:0] onehot2idx(input thr_oh_t oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_THR; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ifu_rr_arb4.sv
// Four-way round-robin arbiter: searches from the thread after last_gnt.
module ifu_rr_arb4
    import ifu_pc_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last_gnt,
    output logic [3:0] gnt,
    output logic       any_gnt
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        gnt     = '0;
        any_gnt = 1'b0;
        // i = NUM_THR wraps back to last_gnt itself, so a lone requester is re-granted.
        for (int i = 1; i <= NUM_THR; i++) begin
            if (!any_gnt && req[last_gnt + 2'(i)]) begin
                gnt[last_gnt + 2'(i)] = 1'b1;
                any_gnt               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ifu_thr_pc_gen.sv
// F-stage per-thread PC generator: four fetch PCs, round-robin thread select, pc_f mux.
module ifu_thr_pc_gen
    import ifu_pc_pkg::*;
#(
    parameter pc_t RESET_PC = RESET_PC_DEF,
    parameter pc_t PC_INC   = PC_INC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  thr_rdy,
    input  logic        stall_f,
    input  logic        redirect_vld,
    input  logic [1:0]  redirect_thr,
    input  logic [47:0] redirect_pc,
    output logic [47:0] t0pc_f,
    output logic [47:0] t1pc_f,
    output logic [47:0] t2pc_f,
    output logic [47:0] t3pc_f,
    output logic [3:0]  thr_f,
    output logic [47:0] pc_f,
    output logic        inst_vld_f
);

    pc_t        tpc     [NUM_THR];
    pc_t        tpc_nxt [NUM_THR];
    logic [1:0] rr_ptr;
    logic [1:0] sel_idx;
    thr_oh_t    gnt;
    logic       any_gnt;

    ifu_rr_arb4 u_arb (
        .req      (thr_rdy),
        .last_gnt (rr_ptr),
        .gnt      (gnt),
        .any_gnt  (any_gnt)
    );

    assign sel_idx = onehot2idx(thr_f);

    // Redirect is applied last so it overrides the same thread's increment.
    always_comb begin
        tpc_nxt = tpc;
        if (!stall_f && inst_vld_f) begin
            tpc_nxt[sel_idx] = tpc[sel_idx] + PC_INC;
        end
        if (redirect_vld) begin
            tpc_nxt[redirect_thr] = redirect_pc & ~pc_t'(3);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the PC array is only four registers and must power up to RESET_PC, so it is reset explicitly.
            for (int i = 0; i < NUM_THR; i++) tpc[i] <= RESET_PC;
            thr_f      <= 4'b0001;
            inst_vld_f <= 1'b0;
            rr_ptr     <= 2'd3;
        end else begin
            tpc <= tpc_nxt;
            if (!stall_f) begin
                if (any_gnt) begin
                    thr_f      <= gnt;
                    inst_vld_f <= 1'b1;
                    rr_ptr     <= onehot2idx(gnt);
                end else begin
                    inst_vld_f <= 1'b0;
                end
            end
        end
    end

    assign t0pc_f = tpc[0];
    assign t1pc_f = tpc[1];
    assign t2pc_f = tpc[2];
    assign t3pc_f = tpc[3];
    assign pc_f   = tpc[sel_idx];

endmodule

// File: tb/tb_ifu_thr_pc_gen.sv
// Directed scoreboard bench for ifu_thr_pc_gen: stimulus pushes hand-computed post-edge state, monitor compares.
module tb_ifu_thr_pc_gen;
    import ifu_pc_pkg::*;

    localparam pc_t R = 48'h0000_0FFF_F000_0020;

    typedef struct packed {
        logic             vld;
        logic [3:0]       thr;
        logic [3:0][47:0] tp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  thr_rdy = '0;
    logic        stall_f = 1'b0;
    logic        redirect_vld = 1'b0;
    logic [1:0]  redirect_thr = '0;
    logic [47:0] redirect_pc = '0;
    logic [47:0] t0pc_f, t1pc_f, t2pc_f, t3pc_f, pc_f;
    logic [3:0]  thr_f;
    logic        inst_vld_f;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    ifu_thr_pc_gen dut (
        .clk          (clk),
        .rst          (rst),
        .thr_rdy      (thr_rdy),
        .stall_f      (stall_f),
        .redirect_vld (redirect_vld),
        .redirect_thr (redirect_thr),
        .redirect_pc  (redirect_pc),
        .t0pc_f       (t0pc_f),
        .t1pc_f       (t1pc_f),
        .t2pc_f       (t2pc_f),
        .t3pc_f       (t3pc_f),
        .thr_f        (thr_f),
        .pc_f         (pc_f),
        .inst_vld_f   (inst_vld_f)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected right after the following edge.
    task automatic step(input logic r, input logic [3:0] rdy, input logic st,
                        input logic rv, input logic [1:0] rt, input pc_t rp,
                        input logic ev, input logic [3:0] eth,
                        input pc_t e0, input pc_t e1, input pc_t e2, input pc_t e3);
        exp_t e;
        @(negedge clk);
        rst = r; thr_rdy = rdy; stall_f = st;
        redirect_vld = rv; redirect_thr = rt; redirect_pc = rp;
        e.vld = ev; e.thr = eth;
        e.tp[0] = e0; e.tp[1] = e1; e.tp[2] = e2; e.tp[3] = e3;
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT presents a new state after every edge.
    initial begin
        exp_t e;
        logic [47:0] exp_pc;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_pc = 'x;
                case (e.thr)
                    4'b0001: exp_pc = e.tp[0];
                    4'b0010: exp_pc = e.tp[1];
                    4'b0100: exp_pc = e.tp[2];
                    4'b1000: exp_pc = e.tp[3];
                    default: exp_pc = 'x;
                endcase
                check("inst_vld_f", 48'(inst_vld_f), 48'(e.vld));
                check("thr_f", 48'(thr_f), 48'(e.thr));
                check("t0pc_f", t0pc_f, e.tp[0]);
                check("t1pc_f", t1pc_f, e.tp[1]);
                check("t2pc_f", t2pc_f, e.tp[2]);
                check("t3pc_f", t3pc_f, e.tp[3]);
                check("pc_f", pc_f, exp_pc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, then nothing ready.
        step(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0001, R, R, R, R);
        for (int i = 0; i < 3; i++)
            step(0, 4'b0000, 0, 0, 0, 0, 0, 4'b0001, R, R, R, R);

        // All ready: rotate 0,1,2,3,0,...; each PC steps once per visit.
        step(0, 4'b1111, 0, 0, 0, 0, 1, 4'b0001, R,   R,   R,   R);
        step(0, 4'b1111, 0, 0, 0, 0, 1, 4'b0010, R+4, R,   R,   R);
        step(0, 4'b1111, 0, 0, 0, 0, 1, 4'b0100, R+4, R+4, R,   R);
        step(0, 4'b1111, 0, 0, 0, 0, 1, 4'b1000, R+4, R+4, R+4, R);
        step(0, 4'b1111, 0, 0, 0, 0, 1, 4'b0001, R+4, R+4, R+4, R+4);
        step(0, 4'b1111, 0, 0, 0, 0, 1, 4'b0010, R+8, R+4, R+4, R+4);
        step(0, 4'b1111, 0, 0, 0, 0, 1, 4'b0100, R+8, R+8, R+4, R+4);
        step(0, 4'b1111, 0, 0, 0, 0, 1, 4'b1000, R+8, R+8, R+8, R+4);

        // Only thread 2 ready, stalled for three cycles (rdy drop during stall ignored).
        step(0, 4'b0100, 0, 0, 0, 0, 1, 4'b0100, R+8, R+8, R+8,  R+8);
        step(0, 4'b0100, 0, 0, 0, 0, 1, 4'b0100, R+8, R+8, R+12, R+8);
        step(0, 4'b0100, 1, 0, 0, 0, 1, 4'b0100, R+8, R+8, R+12, R+8);
        step(0, 4'b0000, 1, 0, 0, 0, 1, 4'b0100, R+8, R+8, R+12, R+8);
        step(0, 4'b0100, 1, 0, 0, 0, 1, 4'b0100, R+8, R+8, R+12, R+8);
        step(0, 4'b0100, 0, 0, 0, 0, 1, 4'b0100, R+8, R+8, R+16, R+8);
        step(0, 4'b0100, 0, 0, 0, 0, 1, 4'b0100, R+8, R+8, R+20, R+8);

        // Select thread 1, then redirect it in the same cycle it would advance.
        step(0, 4'b0010, 0, 0, 0, 0,              1, 4'b0010, R+8,  R+8,  R+24, R+8);
        step(0, 4'b0010, 0, 1, 1, 48'h1237,       1, 4'b0010, R+8,  48'h1234, R+24, R+8);
        // Redirect a non-selected thread; thread 1 still advances.
        step(0, 4'b0010, 0, 1, 0, 48'h5678,       1, 4'b0010, 48'h5678, 48'h1238, R+24, R+8);

        // Thread 3 pushed to the top of the address space, then wraps to 0.
        step(0, 4'b1000, 0, 1, 3, 48'hFFFF_FFFF_FFFF, 1, 4'b1000, 48'h5678, 48'h123C, R+24, 48'hFFFF_FFFF_FFFC);
        step(0, 4'b1000, 0, 0, 0, 0, 1, 4'b1000, 48'h5678, 48'h123C, R+24, 48'h0);
        step(0, 4'b0000, 0, 0, 0, 0, 0, 4'b1000, 48'h5678, 48'h123C, R+24, 48'h4);
        step(0, 4'b0000, 0, 0, 0, 0, 0, 4'b1000, 48'h5678, 48'h123C, R+24, 48'h4);

        // Redirect lands even while stalled; no advance from an invalid slot.
        step(0, 4'b1111, 1, 1, 2, 48'hABC0, 0, 4'b1000, 48'h5678, 48'h123C, 48'hABC0, 48'h4);
        step(0, 4'b0001, 0, 0, 0, 0,        1, 4'b0001, 48'h5678, 48'h123C, 48'hABC0, 48'h4);

        // Reset mid-stream discards a concurrent redirect.
        step(1, 4'b1111, 0, 1, 0, 48'h9990, 0, 4'b0001, R, R, R, R);
        step(0, 4'b1111, 0, 0, 0, 0,        1, 4'b0001, R, R, R, R);

        @(negedge clk);
        thr_rdy = '0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_thr_pc_gen.md
Name: ifu_thr_pc_gen

Overview:
- F-stage per-thread PC generator for the 4-thread SPARC IFU.
- Holds one 48-bit fetch PC per thread and picks the fetch thread each cycle with a round-robin arbiter over ready threads.
- Drives pc_f, thr_f, inst_vld_f and t0pc_f..t3pc_f, the signals the F-stage PC mux-select checker consumes.
- Guarantees pc_f equals the selected thread's tNpc_f in every cycle.

Parameters:
- RESET_PC, 48'h0000_0FFF_F000_0020, power-on fetch PC loaded into all four thread PCs.
- PC_INC, 48'd4, PC advance per issued instruction.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- thr_rdy  input  4  per-thread ready-to-fetch mask; bit N is thread N.
- stall_f  input  1  F-stage stall; freezes selection and PC advance.
- redirect_vld  input  1  PC redirect (branch or trap) for one thread.
- redirect_thr  input  2  thread index of the redirect.
- redirect_pc  input  48  redirect target; bits [1:0] are forced to 0.
- t0pc_f  output  48  thread 0 fetch PC.
- t1pc_f  output  48  thread 1 fetch PC.
- t2pc_f  output  48  thread 2 fetch PC.
- t3pc_f  output  48  thread 3 fetch PC.
- thr_f  output  4  one-hot selected thread.
- pc_f  output  48  PC of the selected thread.
- inst_vld_f  output  1  fetch slot holds a valid instruction.

Behaviour:
- Reset (rst high at the edge):
  - tpc[0..3] <= RESET_PC; thr_f <= 4'b0001; inst_vld_f <= 0; RR pointer <= thread 3, so thread 0 has highest priority next.
  - Reset mid-operation discards any pending redirect or advance in that cycle.
- pc_f is a combinational mux of tpc by thr_f. tNpc_f = tpc[N], driven directly from the registers. thr_f is always exactly one-hot, including when inst_vld_f = 0.
- Advance, at an edge with !stall_f:
  - If inst_vld_f = 1: tpc[sel] <= tpc[sel] + PC_INC, modulo 2^48 (48'hFFFF_FFFF_FFFC wraps to 0).
  - Selection: 4-way round robin over thr_rdy, searching from the thread after the current pointer.
    - Grant found: thr_f <= grant, inst_vld_f <= 1, pointer <= grant.
    - No ready thread: inst_vld_f <= 0; thr_f and pointer hold.
  - A thread may be re-selected back-to-back when it is the only ready one.
- Stall (stall_f = 1): thr_f, inst_vld_f, pointer and all tpc hold, except for a redirect. thr_rdy changes are ignored until the stall releases.
- Redirect (redirect_vld = 1): tpc[redirect_thr] <= {redirect_pc[47:2], 2'b00}.
  - Applies regardless of stall_f.
  - Takes priority over the +PC_INC of the same thread in the same cycle (the increment is dropped).
  - Redirecting a non-selected thread does not affect the selected thread's increment.
  - Redirecting the currently selected thread does not change thr_f or inst_vld_f; pc_f follows the new tpc next cycle.
- Latency:
  - Redirect to visible tNpc_f: 1 cycle.
  - thr_rdy to thr_f and inst_vld_f: 1 cycle.
- Invariants, held by construction:
  - pc_f == tpc[onehot2idx(thr_f)] every cycle.
  - Every tpc[1:0] == 2'b00.

Decomposition:
- Shared package ifu_pc_pkg:
  - NUM_THR = 4, PC_W = 48, PC_INC, RESET_PC default.
  - typedef pc_t (48-bit), typedef thr_oh_t (4-bit).
  - Function onehot2idx.
- Sub-module ifu_rr_arb4: 4-bit request, 2-bit last-grant pointer in, one-hot grant and any_gnt out, purely combinational.
- Top holds the PC registers, the pointer, the output regs and the pc_f mux.

Test Plan:
- Reset, then thr_rdy = 4'b0000 for 3 cycles -> inst_vld_f = 0, thr_f = 0001, pc_f = t0pc_f = 48'h0FFF_F000_0020.
- thr_rdy = 4'b1111, no stall, 8 cycles -> thr_f sequence 0001, 0010, 0100, 1000, 0001, ...; each tNpc_f advances by 4 once per 4 cycles; pc_f == selected tNpc_f every cycle.
- Only thread 2 ready, stall_f high for cycles 3-5 -> thr_f = 0100 throughout; t2pc_f frozen during the stall; after release it steps +4 per cycle.
- Thread 1 selected with inst_vld_f = 1, redirect_vld with redirect_thr = 1, redirect_pc = 48'h0000_0000_1237 in the same cycle -> next cycle t1pc_f = 48'h0000_0000_1234 (not old + 4).
- t3pc_f forced via redirect to 48'hFFFF_FFFF_FFFC, only thread 3 ready -> after one issue t3pc_f = 48'h0; no X; others unchanged.
- Reset asserted mid-stream with redirect_vld also high -> all tNpc_f = RESET_PC, inst_vld_f = 0, thr_f = 0001 next cycle; the redirect is discarded.
